seq_div_ctrl: RTL and testbench
===============================

Name: seq_div_ctrl

Overview:
- Multi-cycle restoring divider controller for the ALU's subtract/overflow datapath.
- Sequences one shared WIDTH+1-bit trial subtraction per cycle, one quotient bit per iteration.
- Handles signed and unsigned operands, divide-by-zero, and the signed MIN/-1 overflow.
- Sits beside the single-cycle ALU and is launched by the EX-stage control with a start/done handshake.

Parameters:
- WIDTH, 16, operand, quotient and remainder width in bits (>=4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset: one clock; reset is asynchronous and active-low.
- start  input  1  launch request; sampled only in IDLE.
- signed_op  input  1  1 = two's-complement division, 0 = unsigned.
- dividend  input  WIDTH  captured on accepted start.
- divisor  input  WIDTH  captured on accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  sticky flag for the last operation.
- overflow  output  1  sticky flag for the last operation.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
  - Internal registers are cleared.
  - Reset mid-operation aborts immediately; the first cycle after release is IDLE.
- States: IDLE, SETUP, ITER, FIXUP, DONE.
- IDLE, start=1 (accepted):
  - Latch operands and signed_op; clear both flags.
  - If divisor==0: set div_by_zero; go to DONE.
  - Else if signed_op and dividend==MIN (1 followed by zeros) and divisor==all-ones: set overflow; go to DONE.
  - Else go to SETUP.
- SETUP (1 cycle):
  - Record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend); both are 0 when unsigned.
  - Replace each signed operand by its magnitude; unsigned operands pass unchanged. The magnitude of MIN is 2^(WIDTH-1), representable as unsigned.
  - Clear the partial remainder P (WIDTH+1 bits); load the shift register Q with the dividend magnitude; iteration counter = WIDTH-1.
- ITER (exactly WIDTH cycles), per cycle:
  - {P,Q} shifts left 1.
  - Compute T = P_shifted - {0,divisor_mag}.
  - T sign bit 0: P=T and Q[0]=1.
  - T sign bit 1: P unchanged and Q[0]=0 (restore).
  - The counter decrements; leave ITER when the counter is 0.
- FIXUP (1 cycle):
  - quotient = q_neg ? -Q : Q.
  - remainder = r_neg ? -P[WIDTH-1:0] : P[WIDTH-1:0].
  - Truncating division: the remainder takes the dividend's sign.
- DONE (1 cycle): done=1; next state IDLE.
  - div_by_zero path: quotient=all ones, remainder=dividend.
  - overflow path: quotient=MIN, remainder=0.
- Latency, start sampled at edge 0:
  - Normal: done is high in cycle WIDTH+3 (19 for WIDTH=16).
  - Exception: done is high in cycle 1.
- Handshake:
  - start is ignored while busy=1 and has no effect on in-flight data.
  - start in the DONE cycle is ignored.
  - start on the first IDLE cycle after DONE is accepted (back-to-back gap of 1 cycle).
- Input changes on dividend, divisor or signed_op after acceptance have no effect.
- Flags and results change only on accept/FIXUP/DONE and persist through IDLE.

Decomposition:
- Shared package/include (div_defs): state encodings (IDLE=0, SETUP=1, ITER=2, FIXUP=3, DONE=4, 3 bits), the WIDTH default, and the MIN-value constant.
- Sub-module div_trial_sub: combinational WIDTH+1-bit subtractor.
  - Inputs: shifted partial remainder, divisor magnitude.
  - Outputs: difference and sign bit.
  - Keeps the datapath separate from the FSM.
- Everything else (FSM, counter, sign fix-up) stays in seq_div_ctrl.

Test Plan:
- Unsigned 100/7 (WIDTH=16): start, signed_op=0 -> done in cycle 19, quotient=14, remainder=2, both flags 0.
- Signed -100/7 (0xFF9C/0x0007) -> quotient=0xFFF2, remainder=0xFFFE.
- Signed 100/-7 -> quotient=0xFFF2, remainder=0x0002.
- Signed 0x8000/0xFFFF -> done in cycle 1, overflow=1, quotient=0x8000, remainder=0.
- Divide by zero: 0x1234/0 -> done in cycle 1, div_by_zero=1, quotient=0xFFFF, remainder=0x1234.
- Start 0xFFFF/1 unsigned; pulse start with new operands during ITER -> result quotient=0xFFFF, remainder=0, and exactly one done.
- Start an operation; drop rst_n in cycle 8 -> all outputs 0 immediately, no done pulse.
- After reset release, start 50/5 -> quotient=10, remainder=0 in cycle 19.

Source files
------------

// File: rtl/div_defs.sv
// Shared definitions for the sequential divider: state encoding, default width
// and the most-negative operand constant.
package div_defs;

  localparam int unsigned DIV_WIDTH = 16;

  localparam logic [DIV_WIDTH-1:0] DIV_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtraction for one restoring-division step:
// shifted partial remainder minus zero-extended divisor magnitude.
module div_trial_sub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   p_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] diff_c,
  output logic             neg_c
);

  logic [WIDTH:0] full_diff;

  assign full_diff = p_shift - {1'b0, divisor};
  assign diff_c    = full_diff[WIDTH-1:0];
  assign neg_c     = full_diff[WIDTH];

endmodule

// File: rtl/seq_div_ctrl.sv
// Multi-cycle restoring divider: one quotient bit per ITER cycle, signed/unsigned,
// with divide-by-zero and MIN/-1 overflow handled at launch.
module seq_div_ctrl
  import div_defs::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sgn_q, sgn_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  // Partial remainder always stays below the divisor, so its top bit is never
  // stored; the WIDTH+1-bit view exists only on the shifted subtractor input.
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH-1:0] t_diff;
  logic             t_neg;

  assign p_shift = {p_q, q_q[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .p_shift (p_shift),
    .divisor (dvs_q),
    .diff_c  (t_diff),
    .neg_c   (t_neg)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    p_d     = p_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          sgn_d = signed_op;
          dz_d  = 1'b0;
          ov_d  = 1'b0;
          if (divisor == '0) begin
            dz_d    = 1'b1;
            quo_d   = ONES;
            rem_d   = dividend;
            state_d = DONE;
          end else if (signed_op && (dividend == MIN_VAL) && (divisor == ONES)) begin
            ov_d    = 1'b1;
            quo_d   = MIN_VAL;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        q_neg_d = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
        r_neg_d = sgn_q & dvd_q[WIDTH-1];
        dvs_d   = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
        q_d     = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
        p_d     = '0;
        cnt_d   = CW'(WIDTH - 1);
        state_d = ITER;
      end
      ITER: begin
        p_d   = t_neg ? p_shift[WIDTH-1:0] : t_diff;
        q_d   = {q_q[WIDTH-2:0], ~t_neg};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIXUP;
      end
      FIXUP: begin
        quo_d   = q_neg_q ? -q_q : q_q;
        rem_d   = r_neg_q ? -p_q : p_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      p_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      p_q     <= p_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Directed scoreboard bench for seq_div_ctrl (WIDTH=16).
module tb_seq_div_ctrl;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero, overflow;
  logic [W-1:0] quotient, remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  seq_div_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.lat = W + 3;
    if (b == 16'h0000) begin
      e.q = 16'hFFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
      e.q = 16'h8000; e.r = 16'h0000; e.ov = 1'b1; e.lat = 1;
    end else if (s) begin
      e.q = 16'($signed(a) / $signed(b));
      e.r = 16'($signed(a) % $signed(b));
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Launch one operation, optionally pulse start mid-flight or in the DONE cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input int inject, input bit start_in_done);
    exp_t e;
    int   got;
    int   lat;
    got = 0;
    lat = 0;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b; signed_op = s;
    @(negedge clk);
    start = 1'b0;
    dividend = 16'($urandom); divisor = 16'($urandom); signed_op = ~s;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int n = 1; n <= 40; n++) begin
      start = (n == inject);
      if (n == inject) begin
        dividend = 16'($urandom); divisor = 16'($urandom);
      end
      if (done === 1'b1) begin
        lat = n;
        got = 1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got == 1) begin
      chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
      chk({tag, "_quotient"}, 32'(quotient), 32'(e.q));
      chk({tag, "_remainder"}, 32'(remainder), 32'(e.r));
      chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
      chk({tag, "_overflow"}, 32'(overflow), 32'(e.ov));
    end
    if (start_in_done) begin
      start = 1'b1;
      dividend = 16'h0005; divisor = 16'h0001;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_done_start_ignored"}, 32'(busy), 32'd0);
      chk({tag, "_held_quotient"}, 32'(quotient), 32'(e.q));
      chk({tag, "_held_dz"}, 32'(div_by_zero), 32'(e.dz));
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("u100_7", 16'd100, 16'd7, 1'b0, 0, 1'b0);
    run_op("s_m100_7", 16'hFF9C, 16'h0007, 1'b1, 0, 1'b0);
    run_op("s_100_m7", 16'h0064, 16'hFFF9, 1'b1, 0, 1'b0);
    run_op("s_ovf", 16'h8000, 16'hFFFF, 1'b1, 0, 1'b1);
    run_op("dz", 16'h1234, 16'h0000, 1'b0, 0, 1'b1);
    run_op("u_8000_ffff", 16'h8000, 16'hFFFF, 1'b0, 0, 1'b0);
    run_op("s_min_7", 16'h8000, 16'h0007, 1'b1, 0, 1'b0);
    run_op("s_m7_m2", 16'hFFF9, 16'hFFFE, 1'b1, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom_range(1, 65535));
      run_op("rand", ra, rb, 1'(i % 2), 0, 1'b0);
    end
    run_op("ffff_1_inject", 16'hFFFF, 16'h0001, 1'b0, 5, 1'b1);

    // Abort an operation with reset in cycle 8
    @(negedge clk);
    start = 1'b1; dividend = 16'h1234; divisor = 16'h0003; signed_op = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("post_rst_no_done", 32'(done), 32'd0);
    run_op("u50_5", 16'd50, 16'd5, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
